// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: a DEPTH-entry byte FIFO whose entries carry
// a header tag, plus a read-side packet byte counter that tracks packet boundaries.
module router_fifo #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty,
   output logic             pkt_active
);

   logic [WIDTH:0]   mem [DEPTH];
   logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
   logic [6:0]       rd_cnt_q, rd_cnt_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH:0]   rd_entry;
   logic             flush;
   logic             wr_acc;
   logic             rd_acc;

   // Extra pointer MSB distinguishes a wrapped (full) state from an empty one.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

   assign flush    = reset || soft_reset;
   assign wr_acc   = write_enb && !full && !flush;
   assign rd_acc   = read_enb && !empty && !flush;
   assign rd_entry = mem[rd_ptr_q[ADDR_W-1:0]];

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rd_cnt_d   = rd_cnt_q;
      data_out_d = data_out_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + 1'b1;
         data_out_d = rd_entry[WIDTH-1:0];
         // A header reloads the count with payload length plus the trailing parity byte.
         if (rd_entry[WIDTH]) begin
            rd_cnt_d = 7'(rd_entry[WIDTH-1:2]) + 7'd1;
         end else if (rd_cnt_q != 7'd0) begin
            rd_cnt_d = rd_cnt_q - 7'd1;
         end
      end
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         rd_cnt_d   = '0;
         data_out_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      data_out_q <= data_out_d;
   end

   // Storage is deliberately left unreset; the pointers define what is valid.
   always_ff @(posedge clock) begin
      if (wr_acc) begin
         mem[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
      end
   end

   assign data_out   = data_out_q;
   assign pkt_active = (rd_cnt_q != 7'd0);

endmodule

// File: tb/tb_router_fifo.sv
// Randomized and directed bench for router_fifo against a queue-based reference model.
module tb_router_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;

   logic             clock = 1'b0;
   logic             reset, soft_reset, write_enb, read_enb, lfd_state;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             full, empty, pkt_active;

   int checks = 0;
   int errs   = 0;

   logic [WIDTH:0] q_m[$];
   int             cnt_m  = 0;
   logic [7:0]     dout_m = 8'h00;

   router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(4)) dut (
      .clock(clock), .reset(reset), .soft_reset(soft_reset),
      .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
      .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
      .pkt_active(pkt_active)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance model with pre-edge occupancy, compare after the edge.
   task automatic step(input logic r, input logic sr, input logic we, input logic re,
                       input logic lfd, input logic [7:0] d);
      logic        was_full, was_empty;
      logic [WIDTH:0] e;
      reset = r; soft_reset = sr; write_enb = we; read_enb = re;
      lfd_state = lfd; data_in = d;
      was_full  = (q_m.size() == DEPTH);
      was_empty = (q_m.size() == 0);
      @(posedge clock);
      #1;
      if (r || sr) begin
         q_m.delete();
         cnt_m  = 0;
         dout_m = 8'h00;
      end else begin
         if (re && !was_empty) begin
            e      = q_m.pop_front();
            dout_m = e[7:0];
            if (e[8])            cnt_m = int'(e[7:2]) + 1;
            else if (cnt_m != 0) cnt_m = cnt_m - 1;
         end
         if (we && !was_full) q_m.push_back({lfd, d});
      end
      chk("data_out", data_out, dout_m);
      chk("empty", empty, q_m.size() == 0);
      chk("full", full, q_m.size() == DEPTH);
      chk("pkt_active", pkt_active, cnt_m != 0);
      chk("not_full_and_empty", full && empty, 1'b0);
   endtask

   logic [7:0] exp2 [5];

   initial begin
      reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
      lfd_state = 1'b0; data_in = '0;

      // Reset with writes pending.
      step(1, 0, 1, 0, 0, 8'h77);
      step(1, 0, 1, 0, 0, 8'h78);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_dout", data_out, 8'h00);
      chk("rst_pkt", pkt_active, 1'b0);
      step(0, 0, 0, 1, 0, 8'h00);
      chk("rst_nothing_stored", data_out, 8'h00);

      // Single packet: header length 3, three payloads (parity last).
      exp2[0] = 8'h0D; exp2[1] = 8'hA1; exp2[2] = 8'hA2; exp2[3] = 8'hA3; exp2[4] = 8'hAD;
      step(0, 0, 1, 0, 1, 8'h0D);
      for (int i = 1; i < 5; i++) step(0, 0, 1, 0, 0, exp2[i]);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 1, 0, 8'h00);
         chk("pkt_byte", data_out, exp2[i]);
         chk("pkt_active_seq", pkt_active, i < 4);
      end
      chk("pkt_end_empty", empty, 1'b1);

      // Fill to full, overflow ignored, drain in order.
      for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 8'(i));
      chk("fill_full", full, 1'b1);
      step(0, 0, 1, 0, 0, 8'hFF);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 1, 0, 8'h00);
         chk("drain_order", data_out, 32'(i));
      end
      chk("drain_empty", empty, 1'b1);

      // Simultaneous read/write while full.
      for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 8'(8'h20 + i));
      step(0, 0, 1, 1, 0, 8'h55);
      chk("rw_full_pop", data_out, 8'h20);
      chk("rw_full_cleared", full, 1'b0);
      step(0, 0, 1, 0, 0, 8'h55);
      chk("rw_refull", full, 1'b1);
      for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 8'h00);
      chk("rw_last_55", data_out, 8'h55);

      // Soft reset mid-packet with a colliding write.
      step(0, 0, 1, 0, 1, 8'h0C);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 8'(8'hB0 + i));
      step(0, 0, 0, 1, 0, 8'h00);
      step(0, 0, 0, 1, 0, 8'h00);
      chk("sr_pkt_before", pkt_active, 1'b1);
      step(0, 1, 1, 0, 0, 8'h99);
      chk("sr_empty", empty, 1'b1);
      chk("sr_pkt", pkt_active, 1'b0);
      chk("sr_dout", data_out, 8'h00);

      // 40 interleaved write/read pairs with random data.
      for (int i = 0; i < 40; i++) begin
         step(0, 0, 1, 0, 1'($urandom_range(0, 3) == 0), 8'($urandom));
         step(0, 0, 0, 1, 0, 8'h00);
      end

      // Fully random traffic, including same-cycle read/write and rare flushes.
      for (int i = 0; i < 400; i++) begin
         step(0, ($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 4) == 0), 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
      $finish;
   end

endmodule
